fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the fetch-queue entry count (power of two, at least 2).
REQ-002 The block SHALL have parameter PC_WIDTH, default 32, meaning the PC and target width.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the fetch PC after reset.
REQ-004 Port clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous and active-high.
REQ-006 Port imem_addr  out  PC_WIDTH  fetch PC driven to the combinational-read instruction memory.
REQ-007 Port imem_inst  in  32  instruction at imem_addr, valid in the same cycle.
REQ-008 Port bp_taken  in  1  direction prediction for imem_addr.
REQ-009 Port btb_hit  in  1  BTB hit for imem_addr.
REQ-010 Port btb_target  in  PC_WIDTH  predicted target when btb_hit=1.
REQ-011 Port redirect_valid  in  1  mispredict or resolved-target redirect from execute.
REQ-012 Port redirect_pc  in  PC_WIDTH  correct next PC when redirect_valid=1.
REQ-013 Port stall  in  1  data or structural hazard hold from the controller.
REQ-014 Port deq_valid  out  1  head entry valid to decode.
REQ-015 Port deq_ready  in  1  decode accepts head entry.
REQ-016 Ports deq_pc (PC_WIDTH), deq_inst (32), deq_pred_taken (1), deq_next_pc_valid (1) and deq_pred_next_pc (PC_WIDTH) SHALL be outputs carrying the head entry fields.
REQ-017 Port count  out  $clog2(DEPTH)+1  current occupancy.
REQ-018 Port waiting  out  1  high while in WAIT_TARGET.

Function
REQ-019 States SHALL be RUN and WAIT_TARGET; imem_addr SHALL equal the internal pc register at all times.
REQ-020 The block SHALL classify an instruction as branch/jump iff imem_inst[6]=1.
REQ-021 The deq handshake SHALL be deq_fire = deq_valid & deq_ready & ~stall; deq_valid SHALL equal (count != 0).
REQ-022 The push condition SHALL be state=RUN & ~redirect_valid & (count<DEPTH | deq_fire); push and pop in the same cycle SHALL leave count unchanged.
REQ-023 A push SHALL write the entry {pc, imem_inst, pred_taken, next_pc_valid, pred_next_pc} at the tail pointer (mod DEPTH).
REQ-024 On push, if the instruction is not a branch or bp_taken=0: pred_taken = branch & bp_taken, next_pc_valid=0, and pc <= pc+4 (mod 2^PC_WIDTH).
REQ-025 On push of a branch with bp_taken=1 and btb_hit=1: pred_taken=1, next_pc_valid=1, pred_next_pc=btb_target, and pc <= btb_target.
REQ-026 On push of a branch with bp_taken=1 and btb_hit=0: pred_taken=1, next_pc_valid=0, pc held, and state -> WAIT_TARGET.
REQ-027 In WAIT_TARGET the block SHALL NOT push, pc SHALL hold, and queued entries SHALL continue to drain.
REQ-028 With no push, pc SHALL hold; a full queue without deq_fire SHALL stall fetch without losing the fetched PC.
REQ-029 redirect_valid SHALL have top priority in any state, regardless of stall: the queue SHALL be flushed (count=0, pointers=0), pc <= redirect_pc, and state -> RUN; no push and no pop SHALL occur that cycle.
REQ-030 While stall=1, no pop SHALL occur and head outputs SHALL hold; push is permitted if count<DEPTH.
REQ-031 Head outputs SHALL be driven directly from storage at the head pointer, giving zero-latency dequeue; a fetched instruction SHALL appear at the head no earlier than the cycle after its push.
REQ-032 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-033 On rst=1 the block SHALL asynchronously set pc=RESET_PC, count=0, head and tail pointers=0, state=RUN, deq_valid=0 and waiting=0.
REQ-034 Reset SHALL cancel any WAIT_TARGET or partially filled queue; entry storage need not be cleared.
REQ-035 Asserting rst mid-stream SHALL discard all entries, and the first push after release SHALL be at RESET_PC.

Verification
REQ-036 Sequential fetch, DEPTH=4, deq_ready=0: four non-branch instructions -> pushes at PCs 0,4,8,C; count=4; pc held at 0x10; release deq_ready -> PCs 0,4,8,C dequeued in order.
REQ-037 Taken branch with BTB hit at pc=0x8, btb_target=0x40 -> entry with pred_taken=1, next_pc_valid=1, pred_next_pc=0x40; next push at pc 0x40.
REQ-038 Taken branch with BTB miss at 0x8 -> waiting=1 with no pushes while the queue drains; redirect_valid with redirect_pc=0x80 -> waiting=0, next push at 0x80.
REQ-039 Redirect with the queue holding 3 entries and simultaneous deq_ready=1 -> no dequeue that cycle; count=0 and deq_valid=0 next cycle; first new entry pc equals redirect_pc.
REQ-040 Full queue with simultaneous deq_fire and push -> count stays 4 and ordering is preserved across pointer wrap; stall=1 -> head outputs stable, no pop.
REQ-041 rst pulsed mid-operation, asynchronously between clock edges -> count=0, deq_valid=0 and pc=RESET_PC immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch PC generator feeding an in-order fetch queue.
//   A single PC register addresses a combinational instruction memory. Each
//   cycle the fetched instruction may be pushed along with its prediction
//   (direction + BTB target). A predicted-taken branch that misses in the BTB
//   parks fetch in WAIT_TARGET until execute redirects it. A redirect has top
//   priority: it flushes the queue and reloads the PC.
// Ports:
//   clk, rst                 clock, async active-high reset
//   imem_addr / imem_inst    fetch PC out, instruction in (same cycle)
//   bp_taken, btb_hit,       prediction inputs for imem_addr
//   btb_target
//   redirect_valid/_pc       flush + PC reload from execute
//   stall                    blocks dequeue (push still allowed when not full)
//   deq_*                    head entry to decode, valid/ready handshake
//   count, waiting           occupancy and WAIT_TARGET indicator
module fetch_queue #(
  parameter int unsigned         DEPTH    = 4,
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [PC_WIDTH-1:0]       imem_addr,
  input  logic [31:0]               imem_inst,
  input  logic                      bp_taken,
  input  logic                      btb_hit,
  input  logic [PC_WIDTH-1:0]       btb_target,
  input  logic                      redirect_valid,
  input  logic [PC_WIDTH-1:0]       redirect_pc,
  input  logic                      stall,
  output logic                      deq_valid,
  input  logic                      deq_ready,
  output logic [PC_WIDTH-1:0]       deq_pc,
  output logic [31:0]               deq_inst,
  output logic                      deq_pred_taken,
  output logic                      deq_next_pc_valid,
  output logic [PC_WIDTH-1:0]       deq_pred_next_pc,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      waiting
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    RUN         = 1'b0,
    WAIT_TARGET = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [AW-1:0]       r_head;
  logic [AW-1:0]       r_tail;
  logic [CW-1:0]       r_count;

  logic [PC_WIDTH-1:0] r_mem_pc   [DEPTH];
  logic [31:0]         r_mem_inst [DEPTH];
  logic                r_mem_pt   [DEPTH];
  logic                r_mem_nv   [DEPTH];
  logic [PC_WIDTH-1:0] r_mem_npc  [DEPTH];

  logic w_deq_fire;
  logic w_pop;
  logic w_push;
  logic w_taken;
  logic w_ent_nv;

  assign w_deq_fire = deq_valid & deq_ready & ~stall;
  // A redirect cancels both sides of the queue in its cycle.
  assign w_pop      = w_deq_fire & ~redirect_valid;
  assign w_push     = (r_state == RUN) & ~redirect_valid &
                      ((r_count < FULL) | w_deq_fire);
  assign w_taken    = imem_inst[6] & bp_taken;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ent_nv    = 1'b0;
    if (redirect_valid) begin
      w_pc_nxt    = redirect_pc;
      w_state_nxt = RUN;
    end else if (w_push) begin
      if (w_taken && btb_hit) begin
        w_ent_nv = 1'b1;
        w_pc_nxt = btb_target;
      end else if (w_taken) begin
        // Target unknown: hold PC and wait for execute to redirect.
        w_state_nxt = WAIT_TARGET;
      end else begin
        w_pc_nxt = r_pc + PC_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (redirect_valid) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + AW'(1);
        if (w_pop)  r_head <= r_head + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry storage is not reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_tail]   <= r_pc;
      r_mem_inst[r_tail] <= imem_inst;
      r_mem_pt[r_tail]   <= w_taken;
      r_mem_nv[r_tail]   <= w_ent_nv;
      r_mem_npc[r_tail]  <= btb_target;
    end
  end

  assign imem_addr         = r_pc;
  assign deq_valid         = (r_count != '0);
  assign deq_pc            = r_mem_pc[r_head];
  assign deq_inst          = r_mem_inst[r_head];
  assign deq_pred_taken    = r_mem_pt[r_head];
  assign deq_next_pc_valid = r_mem_nv[r_head];
  assign deq_pred_next_pc  = r_mem_npc[r_head];
  assign count             = r_count;
  assign waiting           = (r_state == WAIT_TARGET);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        bp_taken, btb_hit, redirect_valid, stall, deq_ready;
  logic [31:0] btb_target, redirect_pc;
  logic        deq_valid, deq_pred_taken, deq_next_pc_valid, waiting;
  logic [31:0] deq_pc, deq_inst, deq_pred_next_pc;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .bp_taken(bp_taken), .btb_hit(btb_hit), .btb_target(btb_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
    .deq_inst(deq_inst), .deq_pred_taken(deq_pred_taken),
    .deq_next_pc_valid(deq_next_pc_valid), .deq_pred_next_pc(deq_pred_next_pc),
    .count(count), .waiting(waiting)
  );

  always #5 clk = ~clk;

  // Instruction memory: mode 0 = no branches, 1 = hashed mix, 2 = branch only at br_addr.
  int          mode = 0;
  logic [31:0] br_addr = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ 32'h0000_1234;
    if (mode == 0)      h[6] = 1'b0;
    else if (mode == 2) h[6] = (a == br_addr);
    return h;
  endfunction

  always @(imem_addr or mode or br_addr) imem_inst = inst_of(imem_addr);

  // Reference model: queue of entries plus fetch PC and wait flag.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          pt;
    bit          nv;
    logic [31:0] npc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_wait;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = 32'h0;
    m_wait = 0;
  endtask

  task automatic model_step();
    ent_t        e;
    bit          pop, push, tk;
    logic [31:0] inst;
    if (redirect_valid) begin
      q.delete();
      m_pc   = redirect_pc;
      m_wait = 0;
      return;
    end
    pop  = (q.size() != 0) && deq_ready && !stall;
    push = !m_wait && ((q.size() < DEPTH) || pop);
    inst = inst_of(m_pc);
    if (pop) void'(q.pop_front());
    if (push) begin
      tk     = inst[6] && bp_taken;
      e.pc   = m_pc;
      e.inst = inst;
      e.pt   = tk;
      e.nv   = 0;
      e.npc  = '0;
      if (tk && btb_hit) begin
        e.nv  = 1;
        e.npc = btb_target;
        m_pc  = btb_target;
      end else if (tk) begin
        m_wait = 1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      q.push_back(e);
    end
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("deq_valid", {31'b0, deq_valid}, {31'b0, q.size() != 0});
    chk("count", {29'b0, count}, q.size());
    chk("waiting", {31'b0, waiting}, {31'b0, m_wait});
    if (q.size() != 0) begin
      chk("deq_pc", deq_pc, q[0].pc);
      chk("deq_inst", deq_inst, q[0].inst);
      chk("deq_pred_taken", {31'b0, deq_pred_taken}, {31'b0, q[0].pt});
      chk("deq_next_pc_valid", {31'b0, deq_next_pc_valid}, {31'b0, q[0].nv});
      if (q[0].nv) chk("deq_pred_next_pc", deq_pred_next_pc, q[0].npc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    bp_taken = 0; btb_hit = 0; btb_target = '0;
    redirect_valid = 0; redirect_pc = '0; stall = 0; deq_ready = 0;
    model_reset();

    @(negedge clk);
    chk("reset_count", {29'b0, count}, 32'd0);
    chk("reset_deq_valid", {31'b0, deq_valid}, 32'd0);
    chk("reset_pc", imem_addr, 32'h0);
    chk("reset_waiting", {31'b0, waiting}, 32'd0);
    rst = 1'b0;
    check_all();

    // Sequential fill with decode blocked, then in-order drain.
    mode = 0;
    repeat (4) tick();
    chk("seq_full_count", {29'b0, count}, 32'd4);
    chk("seq_full_pc", imem_addr, 32'h10);
    repeat (2) tick();
    chk("seq_pc_held", imem_addr, 32'h10);
    deq_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_order", deq_pc, 32'(i * 4));
      tick();
    end
    chk("full_pushpop_count", {29'b0, count}, 32'd4);

    // Taken branch, BTB hit at 0x8.
    deq_ready = 0; redirect_valid = 1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 0;
    mode = 2; br_addr = 32'h8; bp_taken = 1; btb_hit = 1; btb_target = 32'h40;
    repeat (3) tick();
    chk("btb_hit_pc", imem_addr, 32'h40);
    tick();
    chk("btb_hit_next", imem_addr, 32'h44);
    deq_ready = 1;
    repeat (2) tick();
    deq_ready = 0;
    chk("btb_hit_entry_pc", deq_pc, 32'h8);
    chk("btb_hit_pt", {31'b0, deq_pred_taken}, 32'd1);
    chk("btb_hit_nv", {31'b0, deq_next_pc_valid}, 32'd1);
    chk("btb_hit_npc", deq_pred_next_pc, 32'h40);

    // Taken branch, BTB miss at 0x8 -> wait, drain, redirect.
    redirect_valid = 1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 0; btb_hit = 0;
    repeat (3) tick();
    chk("miss_waiting", {31'b0, waiting}, 32'd1);
    chk("miss_count", {29'b0, count}, 32'd3);
    deq_ready = 1;
    repeat (4) tick();
    chk("miss_drained", {29'b0, count}, 32'd0);
    chk("miss_pc_held", imem_addr, 32'h8);
    redirect_valid = 1; redirect_pc = 32'h80; deq_ready = 0;
    tick();
    chk("miss_redir_wait", {31'b0, waiting}, 32'd0);
    chk("miss_redir_pc", imem_addr, 32'h80);
    redirect_valid = 0;
    tick();
    chk("miss_first_push", deq_pc, 32'h80);

    // Redirect while holding 3 entries and decode ready.
    mode = 0;
    repeat (2) tick();
    chk("redir_pre_count", {29'b0, count}, 32'd3);
    redirect_valid = 1; redirect_pc = 32'h200; deq_ready = 1;
    tick();
    chk("redir_count", {29'b0, count}, 32'd0);
    chk("redir_deq_valid", {31'b0, deq_valid}, 32'd0);
    redirect_valid = 0; deq_ready = 0;
    tick();
    chk("redir_first", deq_pc, 32'h200);

    // Full queue under stall, then push+pop across the wrap.
    repeat (3) tick();
    stall = 1; deq_ready = 1;
    repeat (2) tick();
    chk("stall_head", deq_pc, 32'h200);
    chk("stall_count", {29'b0, count}, 32'd4);
    stall = 0;
    tick();
    chk("wrap_count", {29'b0, count}, 32'd4);
    chk("wrap_head", deq_pc, 32'h204);

    // Asynchronous reset between edges.
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", {29'b0, count}, 32'd0);
    chk("async_rst_valid", {31'b0, deq_valid}, 32'd0);
    chk("async_rst_pc", imem_addr, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; deq_ready = 0;
    check_all();
    tick();
    chk("post_rst_first", deq_pc, 32'h0);

    // Randomized traffic.
    mode = 1;
    for (int i = 0; i < 3000; i++) begin
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = $urandom & 32'h0000_0FFC;
      stall          = ($urandom_range(0, 99) < 20);
      deq_ready      = ($urandom_range(0, 99) < 60);
      bp_taken       = $urandom_range(0, 1);
      btb_hit        = $urandom_range(0, 1);
      btb_target     = $urandom & 32'h0000_0FFC;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
